peak_report_framer: RTL and testbench

- Sits directly downstream of the range detector's peak output stream.
- Consumes single-beat 256-bit peak records ({peak_num_i, peak_num_q, peak_val_i, peak_val_q, peak_result_i, peak_result_q}, MSB first).
- Tags each record with the chirp counter_id that was current when the record arrived.
- Buffers records in a small FIFO and serialises each one as a fixed 6-beat, 64-bit AXI-Stream frame for the Ethernet/UDP transmit path.
- Never back-pressures the detector; counts records it has to drop.

---
 rtl/peak_report_pkg.sv | 65 ++++++
 rtl/peak_report_framer_if.sv | 24 ++
 rtl/peak_record_fifo.sv | 65 ++++++
 rtl/peak_report_framer.sv | 169 ++++++++++++++++
 tb/tb_peak_report_framer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/peak_report_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : peak_report_pkg
//  Description : Shared constants, record field slices, frame beat indices,
//                framer state encoding and the beat-content builder used by
//                the peak report framer.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package peak_report_pkg;

    localparam int          FRAME_BEATS         = 6;
    localparam logic [31:0] DEFAULT_FRAME_MAGIC = 32'h504B504B;   // "PKPK"

    localparam int REC_W   = 256;
    localparam int CID_W   = 64;
    localparam int BEAT_W  = 64;
    localparam int ENTRY_W = CID_W + REC_W;

    // Record field slices (record is MSB-first on the detector bus)
    localparam int NUM_MSB   = 255;
    localparam int NUM_LSB   = 192;
    localparam int VAL_I_MSB = 191;
    localparam int VAL_I_LSB = 128;
    localparam int VAL_Q_MSB = 127;
    localparam int VAL_Q_LSB = 64;
    localparam int IDX_MSB   = 63;
    localparam int IDX_LSB   = 0;

    // Beat indices within a frame
    localparam logic [2:0] BEAT_HDR   = 3'd0;
    localparam logic [2:0] BEAT_CID   = 3'd1;
    localparam logic [2:0] BEAT_NUM   = 3'd2;
    localparam logic [2:0] BEAT_VAL_I = 3'd3;
    localparam logic [2:0] BEAT_VAL_Q = 3'd4;
    localparam logic [2:0] BEAT_IDX   = 3'd5;

    localparam logic [15:0] HDR_BEAT_COUNT = 16'(FRAME_BEATS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Content of one frame beat for a given beat index
    function automatic logic [BEAT_W-1:0] build_beat(
        input logic [2:0]       beat,
        input logic [31:0]      magic,
        input logic [15:0]      seq,
        input logic [CID_W-1:0] cid,
        input logic [REC_W-1:0] rec
    );
        case (beat)
            BEAT_HDR:   build_beat = {magic, seq, HDR_BEAT_COUNT};
            BEAT_CID:   build_beat = cid;
            BEAT_NUM:   build_beat = rec[NUM_MSB:NUM_LSB];
            BEAT_VAL_I: build_beat = rec[VAL_I_MSB:VAL_I_LSB];
            BEAT_VAL_Q: build_beat = rec[VAL_Q_MSB:VAL_Q_LSB];
            BEAT_IDX:   build_beat = rec[IDX_MSB:IDX_LSB];
            default:    build_beat = '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/peak_report_framer_if.sv
`default_nettype none
// ============================================================================
//  Module      : peak_report_framer_if
//  Description : AXI-Stream style bundle used for both the peak record input
//                and the framed 64-bit output.
//  Ports       : tdata/tvalid/tlast/tkeep (master -> slave), tready (back)
//  Revision    : 1.0 - initial release
// ============================================================================
interface peak_report_framer_if #(
    parameter int DATA_W = 64
);
    localparam int KEEP_W = DATA_W / 8;

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [KEEP_W-1:0] tkeep;

    modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);

endinterface
`default_nettype wire

// File: rtl/peak_record_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : peak_record_fifo
//  Description : Synchronous FIFO, first-word-fall-through read data.
//                A push while full is accepted only if a pop happens on the
//                same edge.
//  Ports       : aclk, aresetn (sync, active-low), push/push_data,
//                pop/pop_data, count, full, empty
//  Revision    : 1.0 - initial release
// ============================================================================
module peak_record_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 320,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign pop_data  = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; empty/full are derived from r_count
    always_ff @(posedge aclk) begin
        if (aresetn && w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/peak_report_framer.sv
`default_nettype none
// ============================================================================
//  Module      : peak_report_framer
//  Description : Tags each 256-bit peak record with the latched chirp
//                counter_id, buffers it and emits it as a fixed 6-beat
//                64-bit stream frame. Never stalls the detector; records that
//                do not fit are counted in a saturating drop counter.
//  Ports       : aclk, aresetn (sync, active-low)
//                s_pk_axis  - peak record input (slave, 256-bit)
//                m_axis     - frame output (master, 64-bit)
//                cfg_latch, counter_id - chirp counter capture
//                seq_num    - sequence number of next frame to start
//                drop_count - saturating count of dropped records
//  Revision    : 1.0 - initial release
// ============================================================================
module peak_report_framer
    import peak_report_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] FRAME_MAGIC = DEFAULT_FRAME_MAGIC
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    peak_report_framer_if.slave         s_pk_axis,
    peak_report_framer_if.master        m_axis,
    input  logic                        cfg_latch,
    input  logic [CID_W-1:0]            counter_id,
    output logic [15:0]                 seq_num,
    output logic [31:0]                 drop_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [CID_W-1:0]   r_cid;
    logic [CID_W-1:0]   w_cid_snap;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_head;
    logic [CID_W-1:0]   w_head_cid;
    logic [REC_W-1:0]   w_head_rec;
    logic [CNT_W-1:0]   w_unused_count;
    logic               w_unused_in;

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_beat, w_beat_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_last, w_last_nxt;
    logic [BEAT_W-1:0]  r_data, w_data_nxt;
    logic [15:0]        r_seq, w_seq_nxt;
    logic [CID_W-1:0]   r_frame_cid;
    logic [REC_W-1:0]   r_frame_rec;
    logic [31:0]        r_drop;
    logic               w_hs;

    // Every input beat is a whole record, so tlast/tkeep carry no information
    assign w_unused_in = ^{s_pk_axis.tlast, s_pk_axis.tkeep};

    assign s_pk_axis.tready = aresetn;

    // A latch pulse coinciding with a record tags that record with the new id
    assign w_cid_snap = cfg_latch ? counter_id : r_cid;

    // A full FIFO still accepts when the framer drains an entry on this edge
    assign w_push = aresetn & s_pk_axis.tvalid & (~w_full | w_pop);
    assign w_drop = aresetn & s_pk_axis.tvalid & ~w_push;

    peak_record_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (w_push),
        .push_data ({w_cid_snap, s_pk_axis.tdata}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .count     (w_unused_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign w_head_cid = w_head[ENTRY_W-1:REC_W];
    assign w_head_rec = w_head[REC_W-1:0];
    assign w_hs       = r_valid & m_axis.tready;

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_data_nxt  = r_data;
        w_seq_nxt   = r_seq;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = SEND;
                    w_beat_nxt  = BEAT_HDR;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = 1'b0;
                    w_data_nxt  = build_beat(BEAT_HDR, FRAME_MAGIC, r_seq, w_head_cid, w_head_rec);
                end
            end
            SEND: begin
                if (w_hs) begin
                    if (r_beat == BEAT_IDX) begin
                        w_seq_nxt  = r_seq + 16'd1;
                        w_beat_nxt = BEAT_HDR;
                        w_last_nxt = 1'b0;
                        if (!w_empty) begin
                            // Back-to-back: header carries the already-bumped sequence number
                            w_pop      = 1'b1;
                            w_data_nxt = build_beat(BEAT_HDR, FRAME_MAGIC, w_seq_nxt, w_head_cid, w_head_rec);
                        end else begin
                            w_state_nxt = IDLE;
                            w_valid_nxt = 1'b0;
                        end
                    end else begin
                        w_beat_nxt = r_beat + 3'd1;
                        w_last_nxt = (w_beat_nxt == BEAT_IDX);
                        w_data_nxt = build_beat(w_beat_nxt, FRAME_MAGIC, r_seq, r_frame_cid, r_frame_rec);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_beat      <= BEAT_HDR;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_data      <= '0;
            r_seq       <= '0;
            r_cid       <= '0;
            r_drop      <= '0;
            r_frame_cid <= '0;
            r_frame_rec <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_data  <= w_data_nxt;
            r_seq   <= w_seq_nxt;
            if (cfg_latch) r_cid <= counter_id;
            if (w_drop && (r_drop != 32'hFFFF_FFFF)) r_drop <= r_drop + 32'd1;
            if (w_pop) begin
                r_frame_cid <= w_head_cid;
                r_frame_rec <= w_head_rec;
            end
        end
    end

    assign m_axis.tdata  = r_data;
    assign m_axis.tvalid = r_valid;
    assign m_axis.tlast  = r_last;
    assign m_axis.tkeep  = '1;
    assign seq_num       = r_seq;
    assign drop_count    = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_peak_report_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_peak_report_framer
//  Description : Directed, table-driven self-checking bench for
//                peak_report_framer.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_peak_report_framer;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         cfg_latch;
    logic [63:0]  counter_id;
    logic [15:0]  seq_num;
    logic [31:0]  drop_count;

    int checks   = 0;
    int failures = 0;

    peak_report_framer_if #(.DATA_W(256)) s_pk ();
    peak_report_framer_if #(.DATA_W(64))  m ();

    peak_report_framer dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_pk_axis  (s_pk),
        .m_axis     (m),
        .cfg_latch  (cfg_latch),
        .counter_id (counter_id),
        .seq_num    (seq_num),
        .drop_count (drop_count)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [255:0]      rec;
        logic [63:0]       cid;
        logic [0:5][63:0]  exp;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Collect one frame starting at the current negedge; tready follows pat[c%4]
    task automatic recv_frame(input string name, input logic [3:0] pat,
                              output logic [0:5][63:0] d, output logic [0:5] l);
        logic [63:0] pd;
        logic        pl;
        logic        stalled;
        int          got;
        got = 0; stalled = 1'b0; d = '0; l = '0; pd = '0; pl = 1'b0;
        for (int c = 0; c < 100 && got < 6; c++) begin
            m.tready = pat[c % 4];
            if (stalled) begin
                chk({name, "_hold_valid"}, {63'b0, m.tvalid}, 64'd1);
                chk({name, "_hold_data"}, m.tdata, pd);
                chk({name, "_hold_last"}, {63'b0, m.tlast}, {63'b0, pl});
            end
            stalled = m.tvalid && !m.tready;
            pd = m.tdata;
            pl = m.tlast;
            if (m.tvalid && m.tready) begin
                d[got] = m.tdata;
                l[got] = m.tlast;
                got++;
            end
            @(negedge aclk);
        end
        m.tready = 1'b1;
        chk({name, "_beats"}, 64'(got), 64'd6);
    endtask

    // Collect n beats with tready=1, counting how many cycles it took
    task automatic recv_beats(input int n, output logic [0:29][63:0] d,
                              output logic [0:29] l, output int cycles);
        int got;
        got = 0; cycles = 0; d = '0; l = '0;
        m.tready = 1'b1;
        while (got < n && cycles < 80) begin
            if (m.tvalid) begin
                d[got] = m.tdata;
                l[got] = m.tlast;
                got++;
            end
            cycles++;
            @(negedge aclk);
        end
    endtask

    task automatic cmp_frame(input string name, input logic [0:5][63:0] d,
                             input logic [0:5] l, input logic [0:5][63:0] exp);
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_b%0d", name, i), d[i], exp[i]);
        chk({name, "_tlast"}, {58'b0, l}, 64'b000001);
    endtask

    task automatic push_one(input logic [255:0] r);
        s_pk.tdata  = r;
        s_pk.tvalid = 1'b1;
        @(negedge aclk);
        s_pk.tvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [0:5][63:0]  d;
        logic [0:5]        l;
        logic [0:29][63:0] bd;
        logic [0:29]       bl;
        logic [255:0]      rec_a, rec_b, rec_x, rec_y;
        logic [0:5][63:0]  e;
        int                cyc;
        int                hs;

        vecs[0].rec = {64'h0000_0001_0000_0002, 64'h10, 64'h20, 64'h0000_0005_0000_0007};
        vecs[0].cid = 64'hA5;
        vecs[0].exp = {64'h504B504B_0000_0006, 64'hA5, 64'h0000_0001_0000_0002,
                       64'h10, 64'h20, 64'h0000_0005_0000_0007};
        vecs[1].rec = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                       64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        vecs[1].cid = 64'h0123_4567_89AB_CDEF;
        vecs[1].exp = {64'h504B504B_0001_0006, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111,
                       64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        vecs[2].rec = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h8000_0000_0000_0001, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[2].cid = 64'hFFFF_FFFF_FFFF_FFFE;
        vecs[2].exp = {64'h504B504B_0002_0006, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
                       64'h0, 64'h8000_0000_0000_0001, 64'hDEAD_BEEF_CAFE_F00D};

        aresetn     = 1'b0;
        cfg_latch   = 1'b0;
        counter_id  = '0;
        s_pk.tdata  = '0;
        s_pk.tvalid = 1'b0;
        s_pk.tlast  = 1'b1;
        s_pk.tkeep  = '1;
        m.tready    = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) @(negedge aclk);
        chk("rst_tvalid", {63'b0, m.tvalid}, 64'd0);
        chk("rst_tlast", {63'b0, m.tlast}, 64'd0);
        chk("rst_tdata", m.tdata, 64'd0);
        chk("rst_seq", 64'(seq_num), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_s_tready", {63'b0, s_pk.tready}, 64'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("run_s_tready", {63'b0, s_pk.tready}, 64'd1);
        chk("run_tkeep", 64'(m.tkeep), 64'hFF);

        // ---------------- table-driven frames ----------------
        for (int i = 0; i < 3; i++) begin
            cfg_latch  = 1'b1;
            counter_id = vecs[i].cid;
            @(negedge aclk);
            cfg_latch   = 1'b0;
            counter_id  = ~vecs[i].cid;
            s_pk.tdata  = vecs[i].rec;
            s_pk.tvalid = 1'b1;
            @(negedge aclk);
            s_pk.tvalid = 1'b0;
            chk($sformatf("v%0d_lat_early", i), {63'b0, m.tvalid}, 64'd0);
            @(negedge aclk);
            chk($sformatf("v%0d_lat_valid", i), {63'b0, m.tvalid}, 64'd1);
            recv_frame($sformatf("v%0d", i), 4'b1111, d, l);
            cmp_frame($sformatf("v%0d", i), d, l, vecs[i].exp);
            chk($sformatf("v%0d_idle", i), {63'b0, m.tvalid}, 64'd0);
        end
        chk("seq_after_table", 64'(seq_num), 64'd3);

        // ---------------- stalled output ----------------
        push_one(vecs[0].rec);
        @(negedge aclk);
        recv_frame("stall", 4'b1001, d, l);
        e = {64'h504B504B_0003_0006, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0001_0000_0002,
             64'h10, 64'h20, 64'h0000_0005_0000_0007};
        cmp_frame("stall", d, l, e);
        chk("stall_idle", {63'b0, m.tvalid}, 64'd0);

        // ---------------- overflow and back-to-back ----------------
        m.tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_pk.tdata  = {64'hAAAA_AAAA_AAAA_AAAA, 64'h0, 64'h0, 64'(i)};
            s_pk.tvalid = 1'b1;
            @(negedge aclk);
        end
        s_pk.tvalid = 1'b0;
        chk("ovf_drop", 64'(drop_count), 64'd1);
        recv_beats(30, bd, bl, cyc);
        chk("ovf_no_gap_cycles", 64'(cyc), 64'd30);
        for (int f = 0; f < 5; f++) begin
            chk($sformatf("ovf_f%0d_hdr", f), bd[6*f], {32'h504B504B, 16'(4 + f), 16'h0006});
            chk($sformatf("ovf_f%0d_idx", f), bd[6*f+5], 64'(f));
            chk($sformatf("ovf_f%0d_tlast", f), {58'b0, bl[6*f +: 6]}, 64'b000001);
        end
        chk("ovf_seq", 64'(seq_num), 64'd9);
        chk("ovf_idle", {63'b0, m.tvalid}, 64'd0);

        // ---------------- latch bypass ----------------
        rec_x = {64'h1, 64'h2, 64'h3, 64'h4};
        rec_y = {64'h5, 64'h6, 64'h7, 64'h8};
        cfg_latch  = 1'b1;
        counter_id = 64'd3;
        @(negedge aclk);
        counter_id  = 64'd7;
        s_pk.tdata  = rec_x;
        s_pk.tvalid = 1'b1;
        @(negedge aclk);
        cfg_latch   = 1'b0;
        counter_id  = 64'd9;
        s_pk.tdata  = rec_y;
        @(negedge aclk);
        s_pk.tvalid = 1'b0;
        counter_id  = 64'd0;
        recv_beats(12, bd, bl, cyc);
        chk("byp_hdr0", bd[0], 64'h504B504B_0009_0006);
        chk("byp_cid0", bd[1], 64'd7);
        chk("byp_idx0", bd[5], 64'd4);
        chk("byp_hdr1", bd[6], 64'h504B504B_000A_0006);
        chk("byp_cid1", bd[7], 64'd7);
        chk("byp_idx1", bd[11], 64'd8);

        // ---------------- sequence wrap ----------------
        force dut.r_seq = 16'hFFFF;
        @(negedge aclk);
        release dut.r_seq;
        @(negedge aclk);
        chk("wrap_pre_seq", 64'(seq_num), 64'hFFFF);
        push_one(rec_x);
        @(negedge aclk);
        recv_frame("wrap_a", 4'b1111, d, l);
        chk("wrap_a_hdr", d[0], 64'h504B504B_FFFF_0006);
        chk("wrap_seq", 64'(seq_num), 64'd0);
        push_one(rec_y);
        @(negedge aclk);
        recv_frame("wrap_b", 4'b1111, d, l);
        chk("wrap_b_hdr", d[0], 64'h504B504B_0000_0006);
        chk("wrap_b_seq", 64'(seq_num), 64'd1);

        // ---------------- reset mid-frame ----------------
        rec_a = vecs[1].rec;
        rec_b = vecs[2].rec;
        s_pk.tdata  = rec_a;
        s_pk.tvalid = 1'b1;
        @(negedge aclk);
        s_pk.tdata  = rec_b;
        @(negedge aclk);
        s_pk.tvalid = 1'b0;
        hs = 0;
        for (int c = 0; c < 20 && hs < 3; c++) begin
            if (m.tvalid && m.tready) hs++;
            @(negedge aclk);
        end
        chk("mid_beat3", m.tdata, rec_a[191:128]);
        chk("mid_drop_pre", 64'(drop_count), 64'd1);
        aresetn = 1'b0;
        @(negedge aclk);
        chk("mid_rst_tvalid", {63'b0, m.tvalid}, 64'd0);
        chk("mid_rst_tlast", {63'b0, m.tlast}, 64'd0);
        chk("mid_rst_seq", 64'(seq_num), 64'd0);
        chk("mid_rst_drop", 64'(drop_count), 64'd0);
        chk("mid_rst_s_tready", {63'b0, s_pk.tready}, 64'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("mid_flushed", {63'b0, m.tvalid}, 64'd0);
        counter_id = 64'h55;
        push_one(vecs[0].rec);
        @(negedge aclk);
        recv_frame("post_rst", 4'b1111, d, l);
        e = {64'h504B504B_0000_0006, 64'h0, 64'h0000_0001_0000_0002,
             64'h10, 64'h20, 64'h0000_0005_0000_0007};
        cmp_frame("post_rst", d, l, e);
        chk("post_rst_seq", 64'(seq_num), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
